// File: rtl/bus_ram_resp_pkg.sv
// Shared definitions for the bus RAM responder: FSM state encoding, byte-lane
// bit positions and the address-window check used by the responder top level.
package bus_ram_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } bus_state_t;

  localparam int LANE_L8   = 0;
  localparam int LANE_L16  = 1;
  localparam int LANE_H24  = 2;
  localparam int LANE_H32  = 3;
  localparam int NUM_LANES = 4;

  // Unsigned 32-bit compare first so addresses below the base never wrap into the window
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth_words);
    logic [31:0] word_idx;
    word_idx = (addr - base) >> 2;
    return (addr >= base) && (word_idx < depth_words);
  endfunction

endpackage

// File: rtl/bus_ram_resp_if.sv
// SoC bus between the CPU bus interface unit (master) and a responder (slave).
interface bus_ram_resp_if;

  logic [31:0] addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        rd_n;
  logic        wr_n;
  logic        l8;
  logic        l16;
  logic        h24;
  logic        h32;
  logic        rdy;
  logic        acc_fault;

  modport master (
    output addr, bus_wdata, rd_n, wr_n, l8, l16, h24, h32,
    input  bus_rdata, rdy, acc_fault
  );

  modport slave (
    input  addr, bus_wdata, rd_n, wr_n, l8, l16, h24, h32,
    output bus_rdata, rdy, acc_fault
  );

endinterface

// File: rtl/bus_ram_resp_array.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a registered read port.
module bus_ram_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic             wr_en,
  input  logic [3:0]       byte_en,
  input  logic [31:0]      wdata,
  input  logic             rd_en,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Storage has no reset so contents survive a bus reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/bus_ram_resp.sv
// Bus RAM responder: latches a strobed request, waits WAIT_STATES cycles, then
// answers with a one-cycle rdy or acc_fault pulse and holds until strobes release.
module bus_ram_resp
  import bus_ram_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic           clk,
  input  logic           rst,
  bus_ram_resp_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  bus_state_t       state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic             load;
  logic             mem_rd, mem_wr;
  logic             rdy_c, fault_c;
  logic             strobe_any, strobe_both;

  logic             req_write;
  logic             req_fault;
  logic [3:0]       req_lanes;
  logic [31:0]      req_wdata;
  logic [IDX_W-1:0] req_idx;

  assign strobe_any  = !bus.rd_n || !bus.wr_n;
  assign strobe_both = !bus.rd_n && !bus.wr_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_write <= 1'b0;
      req_fault <= 1'b0;
      req_lanes <= '0;
      req_wdata <= '0;
      req_idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        req_write             <= !bus.wr_n;
        req_fault             <= strobe_both ||
                                 !addr_in_window(bus.addr, ADDR_BASE, 32'(DEPTH_WORDS));
        req_lanes[LANE_L8]    <= bus.l8;
        req_lanes[LANE_L16]   <= bus.l16;
        req_lanes[LANE_H24]   <= bus.h24;
        req_lanes[LANE_H32]   <= bus.h32;
        req_wdata             <= bus.bus_wdata;
        req_idx               <= IDX_W'((bus.addr - ADDR_BASE) >> 2);
      end
    end
  end

  // Read is issued on the edge into RESP so data is valid during the rdy cycle;
  // the write happens on the edge leaving RESP so a reset in RESP cancels it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    rdy_c      = 1'b0;
    fault_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe_any) begin
          load       = 1'b1;
          cnt_next   = 4'(WAIT_STATES);
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!strobe_any) begin
          state_next = ST_IDLE;
        end else if (cnt == 4'd0) begin
          mem_rd     = !req_write && !req_fault;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        rdy_c      = !req_fault;
        fault_c    = req_fault;
        mem_wr     = req_write && !req_fault;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!strobe_any) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.rdy       = rdy_c;
  assign bus.acc_fault = fault_c;

  bus_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .idx     (req_idx),
    .wr_en   (mem_wr),
    .byte_en (req_lanes),
    .wdata   (req_wdata),
    .rd_en   (mem_rd),
    .rdata   (bus.bus_rdata)
  );

endmodule

// File: tb/tb_bus_ram_resp.sv
// Scoreboard bench: two responders (1 and 3 wait states) share one stimulus stream
// and are checked against a word-array model of the RAM.
module tb_bus_ram_resp;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          DEPTH = 16;

  typedef struct {
    bit          fault;
    bit          is_read;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  lanes = '0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;

  exp_t        exp_q [2][$];
  int          resp_cnt [2];
  logic [31:0] exp_rdata [2];
  logic [31:0] model [DEPTH];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  bus_ram_resp_if bus1 ();
  bus_ram_resp_if bus3 ();

  assign bus1.addr = addr;   assign bus3.addr = addr;
  assign bus1.bus_wdata = wdata; assign bus3.bus_wdata = wdata;
  assign bus1.rd_n = rd_n;   assign bus3.rd_n = rd_n;
  assign bus1.wr_n = wr_n;   assign bus3.wr_n = wr_n;
  assign bus1.l8  = lanes[0]; assign bus3.l8  = lanes[0];
  assign bus1.l16 = lanes[1]; assign bus3.l16 = lanes[1];
  assign bus1.h24 = lanes[2]; assign bus3.h24 = lanes[2];
  assign bus1.h32 = lanes[3]; assign bus3.h32 = lanes[3];

  bus_ram_resp #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) dut_ws1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  bus_ram_resp #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut_ws3 (
    .clk (clk), .rst (rst), .bus (bus3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit in_window(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < 4 * DEPTH);
  endfunction

  task automatic check_output(input string name, input int d,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s (dut ws%0d): actual %h, required %h", name, ws_of(d), act, req);
    end
  endtask

  // Per-cycle monitor: pops the scoreboard on every pulse and tracks the held read data
  task automatic monitor(input int d, input logic r, input logic f, input logic [31:0] rd);
    exp_t e;
    if (!rst) begin
      exp_rdata[d] = '0;
      check_output("reset_rdy", d, {31'b0, r}, 32'd0);
      check_output("reset_fault", d, {31'b0, f}, 32'd0);
      check_output("reset_rdata", d, rd, 32'd0);
    end else begin
      check_output("rdy_fault_exclusive", d, {31'b0, r & f}, 32'd0);
      if (r || f) begin
        if (exp_q[d].size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse (dut ws%0d): actual rdy=%b fault=%b, required none",
                   ws_of(d), r, f);
        end else begin
          e = exp_q[d].pop_front();
          resp_cnt[d]++;
          check_output("resp_is_fault", d, {31'b0, f}, {31'b0, e.fault});
          check_output("resp_latency_cycle", d, cyc, e.due);
          if (e.is_read && !e.fault) exp_rdata[d] = e.data;
        end
      end
      check_output("rdata_value", d, rd, exp_rdata[d]);
    end
  endtask

  always @(negedge clk) begin
    monitor(0, bus1.rdy, bus1.acc_fault, bus1.bus_rdata);
    monitor(1, bus3.rdy, bus3.acc_fault, bus3.bus_rdata);
  end

  // One complete access: drive, predict, wait for both responders, release strobes
  task automatic apply_stimulus(input bit is_write, input bit both,
                                input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ln);
    exp_t e;
    bit   fault;
    int   idx;
    int   target [2];
    @(posedge clk); #1;
    addr  = a;
    wdata = wd;
    lanes = ln;
    rd_n  = !(!is_write || both);
    wr_n  = !(is_write || both);
    fault = both || !in_window(a);
    idx   = fault ? 0 : int'((a - BASE) >> 2);
    e.fault   = fault;
    e.is_read = !is_write && !both;
    e.data    = fault ? 32'd0 : model[idx];
    for (int d = 0; d < 2; d++) begin
      e.due = cyc + 2 + ws_of(d);
      exp_q[d].push_back(e);
      target[d] = resp_cnt[d] + 1;
    end
    if (!fault && is_write) begin
      for (int b = 0; b < 4; b++) begin
        if (ln[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    for (int n = 0; n < 40 && (resp_cnt[0] < target[0] || resp_cnt[1] < target[1]); n++) begin
      @(posedge clk);
    end
    if (resp_cnt[0] < target[0] || resp_cnt[1] < target[1]) begin
      checks++;
      errors++;
      $display("[TB] FAIL response_timeout: actual %0d/%0d responses, required %0d/%0d",
               resp_cnt[0], resp_cnt[1], target[0], target[1]);
      exp_q[0].delete();
      exp_q[1].delete();
    end
    @(posedge clk); #1;
    rd_n = 1'b1;
    wr_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 32'(4 * $urandom_range(1, 8));
      1:       return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      2:       return 32'hFFFF_FFFC;
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      addr  = $urandom;
      wdata = $urandom;
      lanes = 4'($urandom);
      rd_n  = 1'($urandom_range(0, 1));
      wr_n  = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    rst  = 1'b1;
    repeat (5) @(posedge clk);

    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, 1'b0, BASE + 32'(4 * i), $urandom, 4'hF);
    end

    apply_stimulus(1'b1, 1'b0, BASE + 32'd4, 32'hDEAD_BEEF, 4'hF);
    apply_stimulus(1'b0, 1'b0, BASE + 32'd4, 32'h0, 4'hF);
    repeat (2) @(posedge clk);

    apply_stimulus(1'b1, 1'b0, BASE + 32'd8, 32'h1122_3344, 4'hF);
    apply_stimulus(1'b1, 1'b0, BASE + 32'd8, 32'h0000_AB00, 4'b0010);
    apply_stimulus(1'b0, 1'b0, BASE + 32'd8, 32'h0, 4'b0001);
    apply_stimulus(1'b1, 1'b0, BASE + 32'd8, 32'h5566_0000, 4'b1100);
    apply_stimulus(1'b0, 1'b0, BASE + 32'd8, 32'h0, 4'b0000);
    apply_stimulus(1'b1, 1'b0, BASE + 32'd8, 32'hFFFF_FFFF, 4'b0000);
    apply_stimulus(1'b0, 1'b0, BASE + 32'd8, 32'h0, 4'hF);

    apply_stimulus(1'b0, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF);
    apply_stimulus(1'b1, 1'b1, BASE + 32'd8, 32'hCAFE_F00D, 4'hF);
    apply_stimulus(1'b0, 1'b0, BASE + 32'd8, 32'h0, 4'hF);
    apply_stimulus(1'b0, 1'b0, BASE + 32'(4 * DEPTH) - 32'd1, 32'h0, 4'hF);
    apply_stimulus(1'b0, 1'b0, BASE - 32'd1, 32'h0, 4'hF);
    apply_stimulus(1'b0, 1'b0, BASE + 32'd3, 32'h0, 4'hF);

    // Abort: write strobe low for two edges only, then released
    @(posedge clk); #1;
    addr  = BASE + 32'd8;
    wdata = 32'h0BAD_0BAD;
    lanes = 4'hF;
    wr_n  = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    wr_n = 1'b1;
    repeat (8) @(posedge clk);
    apply_stimulus(1'b0, 1'b0, BASE + 32'd8, 32'h0, 4'hF);

    // Reset while both responders sit in WAIT
    @(posedge clk); #1;
    addr  = BASE + 32'd8;
    wdata = 32'h7777_7777;
    lanes = 4'hF;
    wr_n  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("async_reset_rdata", 0, bus1.bus_rdata, 32'd0);
    check_output("async_reset_rdata", 1, bus3.bus_rdata, 32'd0);
    @(posedge clk); #1;
    wr_n = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    apply_stimulus(1'b0, 1'b0, BASE + 32'd8, 32'h0, 4'hF);

    for (int i = 0; i < 150; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                     rand_addr(), $urandom, 4'($urandom));
    end

    repeat (10) @(posedge clk);
    check_output("queue_drained", 0, 32'(exp_q[0].size()), 32'd0);
    check_output("queue_drained", 1, 32'(exp_q[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
